reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised successor to the board-level power-on auto-reset logic. Generates per-domain active-high SoC resets from three sources: power-on/PLL (async reset_ni), a debounced raw pushbutton, and a software reset pulse. Holds all domains for a programmable power-on interval, then releases them in a staggered order, and records the cause of the last reset. Sits in each board top between the pins and xgsoc, replacing per-board ad-hoc counters.

Parameters:
NUM_DOMAINS, 2, number of reset outputs, >=1; domain 0 is released first.
POR_CYCLES, 32, clk edges all domains are held after the last reset request clears, >=1.
DEBOUNCE_CYCLES, 12000, consecutive stable synchronised samples required to accept a button level change, >=1.
STAGGER_CYCLES, 16, clk edges between release of domain i and domain i+1, >=1.

Ports:
clk  input  1  system clock
reset_ni  input  1  asynchronous active-low master reset (power-on/PLL lock)
btn_ni  input  1  raw pushbutton, active-low, asynchronous to clk, bouncy
sw_reset_i  input  1  single-cycle synchronous software reset request
reset_o  output  NUM_DOMAINS  active-high domain resets, asynchronous assert via reset_ni, synchronous release
done_o  output  1  high when all domains are released (state RUN)
cause_o  output  2  last reset cause: 01 POR, 10 button, 11 software; 00 never driven

Behaviour:
- Clock domain: one clock (clk); reset is asynchronous and active-low (reset_ni).
- reset_ni low, asynchronous: reset_o = all ones, done_o = 0, cause_o = 01, state HOLD, counter 0, synchroniser and debounced button = 1 (released), debounce counter 0.
- Button path: 2-FF synchroniser. Debounce counter counts while the synchronised value != debounced value and clears when they are equal. When the count reaches DEBOUNCE_CYCLES, the debounced value takes the synchronised value and the counter clears. btn_req = debounced value == 0 (level, not edge).
- Counter width: $clog2(max(POR_CYCLES, DEBOUNCE_CYCLES, NUM_DOMAINS*STAGGER_CYCLES)+1). No wrap is possible in any state.
- HOLD: reset_o all ones, done_o 0. Counter clears while btn_req = 1 (reset extends for as long as the button is held); otherwise it increments. sw_reset_i is ignored. At the edge where the counter == POR_CYCLES-1 and btn_req = 0: reset_o[0] <= 0 and the counter clears. The state then goes to RELEASE, or to RUN with done_o <= 1 if NUM_DOMAINS = 1.
- RELEASE: the counter increments. At the edge where the counter == i*STAGGER_CYCLES-1, reset_o[i] <= 0 for i = 1..N-1. Released domains stay released. The edge that releases domain N-1 also sets done_o <= 1 and moves the state to RUN.
- RUN: hold outputs. Counter idle at 0.
- Reset request in RELEASE or RUN (btn_req = 1 or sw_reset_i = 1), at the next edge: reset_o <= all ones, done_o <= 0, counter <= 0, state <= HOLD.
- cause_o <= 10 if btn_req, else 11. If both requests occur in the same cycle, the button wins (10).
- cause_o holds until the next request or reset_ni assertion.
- reset_ni asserted mid-sequence: immediate asynchronous return to the reset values above, from any state.
- Latency from the first edge after reset_ni rises, with the button released: reset_o[0] falls at edge POR_CYCLES. reset_o[i] falls at edge POR_CYCLES + i*STAGGER_CYCLES (1-based edge count).

Test Plan:
(Params: NUM_DOMAINS=3, POR_CYCLES=8, DEBOUNCE_CYCLES=4, STAGGER_CYCLES=3.)
- Power-on: release reset_ni, btn_ni=1 -> reset_o=111 through edge 7; 110 at edge 8; 100 at edge 11; 000 and done_o=1 at edge 14; cause_o=01.
- Debounce reject: in RUN, pulse btn_ni low for 3 cycles, repeated 3 times with 1-cycle highs -> reset_o stays 000, done_o stays 1.
- Button reset: in RUN, hold btn_ni low for 20 cycles, then release -> reset_o=111 and cause_o=10 exactly 2+4+1 edges after the low level. Hold persists while pressed. Domain 0 releases POR_CYCLES edges after the debounced release, then staggered as above.
- Software reset: 1-cycle sw_reset_i in RUN -> reset_o=111 at the next edge, cause_o=11, full POR + stagger re-release. sw_reset_i pulsed in HOLD -> no effect on timing.
- Abort in RELEASE: sw_reset_i while reset_o=110 -> reset_o=111 next edge, counter restarts, domain 0 released 8 edges later.
- Async reset mid-RELEASE: drop reset_ni between edges -> reset_o=111, done_o=0, cause_o=01 immediately, no clock needed. Simultaneous btn_req and sw_reset_i in RUN -> cause_o=10.

Source files
------------

// File: rtl/reset_sequencer.sv
// Board reset sequencer: combines power-on, debounced pushbutton and software reset
// requests, holds all domains for a power-on interval, then releases them staggered.
module reset_sequencer #(
    parameter int NUM_DOMAINS     = 2,
    parameter int POR_CYCLES      = 32,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int STAGGER_CYCLES  = 16
) (
    input  logic                   clk,
    input  logic                   reset_ni,
    input  logic                   btn_ni,
    input  logic                   sw_reset_i,
    output logic [NUM_DOMAINS-1:0] reset_o,
    output logic                   done_o,
    output logic [1:0]             cause_o
);

    localparam int MAX_PD  = (POR_CYCLES > DEBOUNCE_CYCLES) ? POR_CYCLES : DEBOUNCE_CYCLES;
    localparam int MAX_ALL = (MAX_PD > NUM_DOMAINS * STAGGER_CYCLES) ? MAX_PD
                                                                     : NUM_DOMAINS * STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);
    localparam int LAST_STG_I = (NUM_DOMAINS > 1) ? ((NUM_DOMAINS - 1) * STAGGER_CYCLES - 1) : 0;

    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]       DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]       POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0]       STG_LAST  = CNT_W'(LAST_STG_I);
    localparam logic [NUM_DOMAINS-1:0] ALL_ONES  = {NUM_DOMAINS{1'b1}};
    localparam logic [1:0]             CAUSE_POR = 2'b01;
    localparam logic [1:0]             CAUSE_BTN = 2'b10;
    localparam logic [1:0]             CAUSE_SW  = 2'b11;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [1:0]             sync_r;
    logic                   btn_db_r;
    logic [CNT_W-1:0]       db_cnt_r;
    logic                   btn_req_s;

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [NUM_DOMAINS-1:0] rst_r, rst_s;
    logic                   done_r, done_s;
    logic [1:0]             cause_r, cause_s;

    // Button synchroniser and debounce filter; the filter only moves after a full stable run
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_r   <= 2'b11;
            btn_db_r <= 1'b1;
            db_cnt_r <= '0;
        end else begin
            sync_r <= {sync_r[0], btn_ni};
            if (sync_r[1] == btn_db_r) begin
                db_cnt_r <= '0;
            end else if (db_cnt_r == DB_LAST) begin
                btn_db_r <= sync_r[1];
                db_cnt_r <= '0;
            end else begin
                db_cnt_r <= db_cnt_r + CNT_ONE;
            end
        end
    end

    assign btn_req_s = ~btn_db_r;

    // Sequencer state register and registered outputs
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= ST_HOLD;
            cnt_r   <= '0;
            rst_r   <= ALL_ONES;
            done_r  <= 1'b0;
            cause_r <= CAUSE_POR;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            rst_r   <= rst_s;
            done_r  <= done_s;
            cause_r <= cause_s;
        end
    end

    // Next-state and next-output logic for the hold / staggered release sequence
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rst_s   = rst_r;
        done_s  = done_r;
        cause_s = cause_r;
        case (state_r)
            ST_HOLD: begin
                rst_s  = ALL_ONES;
                done_s = 1'b0;
                // A held button keeps restarting the power-on interval
                if (btn_req_s) begin
                    cnt_s = '0;
                end else if (cnt_r == POR_LAST) begin
                    rst_s[0] = 1'b0;
                    cnt_s    = '0;
                    if (NUM_DOMAINS == 1) begin
                        state_s = ST_RUN;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (btn_req_s || sw_reset_i) begin
                    state_s = ST_HOLD;
                    cnt_s   = '0;
                    rst_s   = ALL_ONES;
                    done_s  = 1'b0;
                    cause_s = btn_req_s ? CAUSE_BTN : CAUSE_SW;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                    for (int i = 1; i < NUM_DOMAINS; i++) begin
                        if (cnt_r == CNT_W'(i * STAGGER_CYCLES - 1)) begin
                            rst_s[i] = 1'b0;
                        end else begin
                            rst_s[i] = rst_r[i];
                        end
                    end
                    if (cnt_r == STG_LAST) begin
                        state_s = ST_RUN;
                        done_s  = 1'b1;
                        cnt_s   = '0;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end
            end
            ST_RUN: begin
                if (btn_req_s || sw_reset_i) begin
                    state_s = ST_HOLD;
                    cnt_s   = '0;
                    rst_s   = ALL_ONES;
                    done_s  = 1'b0;
                    cause_s = btn_req_s ? CAUSE_BTN : CAUSE_SW;
                end else begin
                    cnt_s = '0;
                end
            end
            default: begin
                state_s = ST_HOLD;
                cnt_s   = '0;
                rst_s   = ALL_ONES;
                done_s  = 1'b0;
            end
        endcase
    end

    assign reset_o = rst_r;
    assign done_o  = done_r;
    assign cause_o = cause_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_reset_sequencer;

    localparam int N   = 3;
    localparam int POR = 8;
    localparam int DEB = 4;
    localparam int STG = 3;

    logic         clk = 1'b0;
    logic         reset_ni;
    logic         btn_ni;
    logic         sw_reset_i;
    logic [N-1:0] reset_o;
    logic         done_o;
    logic [1:0]   cause_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS(N),
        .POR_CYCLES(POR),
        .DEBOUNCE_CYCLES(DEB),
        .STAGGER_CYCLES(STG)
    ) dut (
        .clk(clk),
        .reset_ni(reset_ni),
        .btn_ni(btn_ni),
        .sw_reset_i(sw_reset_i),
        .reset_o(reset_o),
        .done_o(done_o),
        .cause_o(cause_o)
    );

    // Model: raw button samples per edge, debounced level, and the number of
    // quiet edges elapsed since the current hold began.
    bit         hist[$];
    bit         m_db;
    int         m_el;
    logic [1:0] m_cause;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [N-1:0] exp_rst(input int el);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (el < POR + i * STG);
        return v;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEB + 3; i++) hist.push_front(1'b1);
        m_db    = 1'b1;
        m_el    = 0;
        m_cause = 2'b01;
    endtask

    task automatic model_step(input bit btn, input bit sw);
        bit req;
        bit flip;
        req = (m_db == 1'b0);
        if (m_el >= POR && (req || sw)) begin
            m_el    = 0;
            m_cause = req ? 2'b10 : 2'b11;
        end else if (m_el < POR && req) begin
            m_el = 0;
        end else if (m_el < POR + (N - 1) * STG) begin
            m_el++;
        end
        // synchronised level seen at this edge is the raw sample from two edges back
        flip = 1'b1;
        for (int j = 1; j <= DEB; j++) if (hist[j] == m_db) flip = 1'b0;
        if (flip) m_db = !m_db;
        hist.push_front(btn);
        if (hist.size() > DEB + 3) void'(hist.pop_back());
    endtask

    // Per-cycle comparison against the model
    always begin
        @(posedge clk or negedge reset_ni);
        if (!reset_ni) model_reset();
        else model_step(btn_ni, sw_reset_i);
        #1;
        chk("reset_o", 32'(reset_o), 32'(exp_rst(m_el)));
        chk("done_o", 32'(done_o), 32'(m_el >= POR + (N - 1) * STG));
        chk("cause_o", 32'(cause_o), 32'(m_cause));
    end

    initial begin
        bit tgt;
        reset_ni   = 1'b0;
        btn_ni     = 1'b1;
        sw_reset_i = 1'b0;
        tick(3);
        chk("lit_reset_rst", 32'(reset_o), 32'h7);
        chk("lit_reset_done", 32'(done_o), 32'h0);
        chk("lit_reset_cause", 32'(cause_o), 32'h1);

        // power-on release
        reset_ni = 1'b1;
        tick(7);  chk("lit_por_e7", 32'(reset_o), 32'h7);
        tick(1);  chk("lit_por_e8", 32'(reset_o), 32'h6);
        tick(3);  chk("lit_por_e11", 32'(reset_o), 32'h4);
        tick(3);  chk("lit_por_e14", 32'(reset_o), 32'h0);
        chk("lit_por_done", 32'(done_o), 32'h1);
        chk("lit_por_cause", 32'(cause_o), 32'h1);

        // bounce shorter than the debounce window is rejected
        repeat (3) begin
            btn_ni = 1'b0; tick(3);
            btn_ni = 1'b1; tick(1);
        end
        tick(8);
        chk("lit_bounce_rst", 32'(reset_o), 32'h0);
        chk("lit_bounce_done", 32'(done_o), 32'h1);

        // held button: 2 sync + 4 debounce + 1 edge
        btn_ni = 1'b0;
        tick(6);  chk("lit_btn_e6", 32'(reset_o), 32'h0);
        tick(1);  chk("lit_btn_e7", 32'(reset_o), 32'h7);
        chk("lit_btn_cause", 32'(cause_o), 32'h2);
        tick(13);
        btn_ni = 1'b1;
        tick(13); chk("lit_btnrel_e13", 32'(reset_o), 32'h7);
        tick(1);  chk("lit_btnrel_e14", 32'(reset_o), 32'h6);
        tick(6);  chk("lit_btnrel_done", 32'(done_o), 32'h1);

        // software reset; a pulse during hold does not disturb timing
        sw_reset_i = 1'b1; tick(1); sw_reset_i = 1'b0;
        chk("lit_sw_rst", 32'(reset_o), 32'h7);
        chk("lit_sw_cause", 32'(cause_o), 32'h3);
        chk("lit_sw_done", 32'(done_o), 32'h0);
        tick(3);
        sw_reset_i = 1'b1; tick(1); sw_reset_i = 1'b0;
        tick(3);  chk("lit_sw_e7", 32'(reset_o), 32'h7);
        tick(1);  chk("lit_sw_e8", 32'(reset_o), 32'h6);

        // abort during release
        tick(1);
        sw_reset_i = 1'b1; tick(1); sw_reset_i = 1'b0;
        chk("lit_abort_rst", 32'(reset_o), 32'h7);
        tick(7);  chk("lit_abort_e7", 32'(reset_o), 32'h7);
        tick(1);  chk("lit_abort_e8", 32'(reset_o), 32'h6);
        tick(6);  chk("lit_abort_done", 32'(done_o), 32'h1);

        // simultaneous button and software request: button wins
        btn_ni = 1'b0;
        tick(6);
        sw_reset_i = 1'b1; tick(1); sw_reset_i = 1'b0;
        btn_ni = 1'b1;
        chk("lit_both_rst", 32'(reset_o), 32'h7);
        chk("lit_both_cause", 32'(cause_o), 32'h2);
        tick(30);
        chk("lit_both_done", 32'(done_o), 32'h1);

        // asynchronous reset in the middle of release
        sw_reset_i = 1'b1; tick(1); sw_reset_i = 1'b0;
        tick(8);
        chk("lit_async_pre", 32'(reset_o), 32'h6);
        #2 reset_ni = 1'b0;
        #2;
        chk("lit_async_rst", 32'(reset_o), 32'h7);
        chk("lit_async_done", 32'(done_o), 32'h0);
        chk("lit_async_cause", 32'(cause_o), 32'h1);
        @(negedge clk);
        reset_ni = 1'b1;
        tick(20);
        chk("lit_async_redone", 32'(done_o), 32'h1);

        // randomized stimulus, checked by the per-cycle model comparison
        tgt = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) tgt = !tgt;
            btn_ni     = ($urandom_range(0, 7) == 0) ? !tgt : tgt;
            sw_reset_i = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 reset_ni = 1'b0;
                @(negedge clk);
                reset_ni = 1'b1;
            end
        end
        sw_reset_i = 1'b0;
        btn_ni     = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
